zigzag_rle_encoder: RTL and testbench

- Entropy-prep stage directly downstream of the DCT/quantization stage.
- Accepts one 8x8 block of quantized DCT coefficients (24.8 fixed point, as produced by the DCT stage).
- Rounds and saturates each coefficient to an integer, scans the block in JPEG zigzag order and emits JPEG-style (run, size, amplitude) symbols over a valid/ready stream.
- The Huffman packer consumes that stream.

---
 rtl/zigzag_rle_encoder.sv | 248 ++++++++++++++++++++++++
 tb/tb_zigzag_rle_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_rle_encoder.sv
`default_nettype none
// ============================================================================
// zigzag_rle_encoder : rounds/saturates an 8x8 block of 24.8 coefficients,
//   zigzag-scans it and emits JPEG (run, size, amplitude) symbols.
//   Optional macro ZIGZAG_RLE_DC_DIFF_EN: DC symbol carries the DC difference.
// Revision: 1.0
// ============================================================================
module zigzag_rle_encoder #(
    parameter int COEF_W = 32,
    parameter int AMP_W  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [64*COEF_W-1:0] blk_coef,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [3:0]           sym_run,
    output logic [3:0]           sym_size,
    output logic [AMP_W-1:0]     sym_amp,
    output logic                 sym_dc,
    output logic                 sym_eob,
    output logic                 sym_last,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DC   = 3'd1,
        S_AC   = 3'd2,
        S_ZRL  = 3'd3,
        S_EOB  = 3'd4
    } state_t;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic signed [COEF_W:0] C_RND   = (COEF_W+1)'(128);
    localparam logic signed [COEF_W:0] C_SAT_P = (COEF_W+1)'(2047);
    localparam logic signed [COEF_W:0] C_SAT_N = (COEF_W+1)'(-2047);

    // Round half up, then clamp to the symmetric +/-2047 range.
    function automatic logic signed [11:0] f_conv(input logic [COEF_W-1:0] c);
        logic signed [COEF_W:0] t;
        t = ($signed({c[COEF_W-1], c}) + C_RND) >>> 8;
        if (t > C_SAT_P) return 12'sd2047;
        if (t < C_SAT_N) return -12'sd2047;
        return 12'(t);
    endfunction

    function automatic logic [3:0] f_size(input logic signed [12:0] v);
        logic [12:0] a;
        logic [3:0]  s;
        a = v[12] ? 13'(-v) : v;
        s = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (a[i]) s = 4'(i + 1);
        end
        return s;
    endfunction

    function automatic logic [11:0] f_amp(input logic signed [12:0] v, input logic [3:0] s);
        logic [12:0] m;
        logic [12:0] r;
        m = (13'd1 << s) - 13'd1;
        r = v[12] ? (13'(v - 13'sd1) & m) : v;
        return 12'(r);
    endfunction

    state_t             state_q;
    logic signed [11:0] buf_q [64];
    logic [5:0]         k_q;
    logic [3:0]         run_q;
    logic [1:0]         pzrl_q;
    logic               blk_ready_q;
    logic               sym_valid_q;
    logic [3:0]         sym_run_q;
    logic [3:0]         sym_size_q;
    logic [AMP_W-1:0]   sym_amp_q;
    logic               sym_dc_q;
    logic               sym_eob_q;
    logic               sym_last_q;

    logic               w_adv;
    logic signed [11:0] w_dc_v;
    logic signed [12:0] w_dc_val;
    logic [3:0]         w_dc_size;
    logic [11:0]        w_dc_amp;
    logic signed [11:0] w_cur;
    logic signed [12:0] w_cur13;
    logic [3:0]         w_ac_size;
    logic [11:0]        w_ac_amp;

`ifdef ZIGZAG_RLE_DC_DIFF_EN
    logic signed [11:0] pred_q;
    assign w_dc_val = {w_dc_v[11], w_dc_v} - {pred_q[11], pred_q};
`else
    assign w_dc_val = {w_dc_v[11], w_dc_v};
`endif

    assign w_adv     = !sym_valid_q || sym_ready;
    assign w_dc_v    = f_conv(blk_coef[COEF_W-1:0]);
    assign w_dc_size = f_size(w_dc_val);
    assign w_dc_amp  = f_amp(w_dc_val, w_dc_size);
    assign w_cur     = buf_q[ZZ[k_q]];
    assign w_cur13   = {w_cur[11], w_cur};
    assign w_ac_size = f_size(w_cur13);
    assign w_ac_amp  = f_amp(w_cur13, w_ac_size);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 64; i++) buf_q[i] <= '0;
            k_q         <= '0;
            run_q       <= '0;
            pzrl_q      <= '0;
            blk_ready_q <= 1'b1;
            sym_valid_q <= 1'b0;
            sym_run_q   <= '0;
            sym_size_q  <= '0;
            sym_amp_q   <= '0;
            sym_dc_q    <= 1'b0;
            sym_eob_q   <= 1'b0;
            sym_last_q  <= 1'b0;
`ifdef ZIGZAG_RLE_DC_DIFF_EN
            pred_q      <= '0;
`endif
        end else begin
            // A taken slot empties unless one of the branches below refills it.
            if (w_adv) sym_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 64; i++)
                            buf_q[i] <= f_conv(blk_coef[i*COEF_W +: COEF_W]);
                        sym_valid_q <= 1'b1;
                        sym_run_q   <= 4'd0;
                        sym_size_q  <= w_dc_size;
                        sym_amp_q   <= AMP_W'(w_dc_amp);
                        sym_dc_q    <= 1'b1;
                        sym_eob_q   <= 1'b0;
                        sym_last_q  <= 1'b0;
                        k_q         <= 6'd1;
                        run_q       <= 4'd0;
                        pzrl_q      <= 2'd0;
                        blk_ready_q <= 1'b0;
                        state_q     <= S_DC;
                    end
                end
                S_DC, S_AC: begin
                    if (w_adv) begin
`ifdef ZIGZAG_RLE_DC_DIFF_EN
                        if (state_q == S_DC) pred_q <= buf_q[0];
`endif
                        state_q <= S_AC;
                        if (w_cur == 12'sd0) begin
                            if (run_q == 4'd15) begin
                                run_q <= 4'd0;
                                if (pzrl_q != 2'd3) pzrl_q <= pzrl_q + 2'd1;
                            end else begin
                                run_q <= run_q + 4'd1;
                            end
                            if (k_q == 6'd63) begin
                                sym_valid_q <= 1'b1;
                                sym_run_q   <= 4'd0;
                                sym_size_q  <= 4'd0;
                                sym_amp_q   <= '0;
                                sym_dc_q    <= 1'b0;
                                sym_eob_q   <= 1'b1;
                                sym_last_q  <= 1'b1;
                                state_q     <= S_EOB;
                            end else begin
                                k_q <= k_q + 6'd1;
                            end
                        end else if (pzrl_q != 2'd0) begin
                            // Hold k; the nonzero coefficient is re-examined after the ZRLs.
                            sym_valid_q <= 1'b1;
                            sym_run_q   <= 4'd15;
                            sym_size_q  <= 4'd0;
                            sym_amp_q   <= '0;
                            sym_dc_q    <= 1'b0;
                            sym_eob_q   <= 1'b0;
                            sym_last_q  <= 1'b0;
                            pzrl_q      <= pzrl_q - 2'd1;
                            if (pzrl_q != 2'd1) state_q <= S_ZRL;
                        end else begin
                            sym_valid_q <= 1'b1;
                            sym_run_q   <= run_q;
                            sym_size_q  <= w_ac_size;
                            sym_amp_q   <= AMP_W'(w_ac_amp);
                            sym_dc_q    <= 1'b0;
                            sym_eob_q   <= 1'b0;
                            sym_last_q  <= (k_q == 6'd63);
                            run_q       <= 4'd0;
                            if (k_q == 6'd63) state_q <= S_EOB;
                            else              k_q     <= k_q + 6'd1;
                        end
                    end
                end
                S_ZRL: begin
                    if (w_adv) begin
                        sym_valid_q <= 1'b1;
                        sym_run_q   <= 4'd15;
                        sym_size_q  <= 4'd0;
                        sym_amp_q   <= '0;
                        sym_dc_q    <= 1'b0;
                        sym_eob_q   <= 1'b0;
                        sym_last_q  <= 1'b0;
                        pzrl_q      <= pzrl_q - 2'd1;
                        if (pzrl_q == 2'd1) state_q <= S_AC;
                    end
                end
                S_EOB: begin
                    // The block's final symbol is on the output; leave once it is taken.
                    if (w_adv) begin
                        state_q     <= S_IDLE;
                        blk_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    blk_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign blk_ready = blk_ready_q;
    assign busy      = (state_q != S_IDLE);
    assign sym_valid = sym_valid_q;
    assign sym_run   = sym_run_q;
    assign sym_size  = sym_size_q;
    assign sym_amp   = sym_amp_q;
    assign sym_dc    = sym_dc_q;
    assign sym_eob   = sym_eob_q;
    assign sym_last  = sym_last_q;

endmodule
`default_nettype wire

// File: tb/tb_zigzag_rle_encoder.sv
`default_nettype none
// ============================================================================
// tb_zigzag_rle_encoder : directed bench with a symbol-list reference model.
// Revision: 1.0
// ============================================================================
module tb_zigzag_rle_encoder;

    localparam int COEF_W = 32;
    localparam int AMP_W  = 12;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 blk_valid = 1'b0;
    logic                 blk_ready;
    logic [64*COEF_W-1:0] blk_coef = '0;
    logic                 sym_valid;
    logic                 sym_ready = 1'b1;
    logic [3:0]           sym_run;
    logic [3:0]           sym_size;
    logic [AMP_W-1:0]     sym_amp;
    logic                 sym_dc;
    logic                 sym_eob;
    logic                 sym_last;
    logic                 busy;

    zigzag_rle_encoder #(.COEF_W(COEF_W), .AMP_W(AMP_W)) dut (
        .clk(clk), .reset(reset),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_coef(blk_coef),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
        .sym_dc(sym_dc), .sym_eob(sym_eob), .sym_last(sym_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  run;
        logic [3:0]  size;
        logic [11:0] amp;
        logic        dc;
        logic        eob;
        logic        last;
    } sym_t;

    sym_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   pred  = 0;
    int   coefs [64];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int conv(input int c);
        longint t;
        t = (longint'(c) + 128) >>> 8;
        if (t > 2047)  t = 2047;
        if (t < -2047) t = -2047;
        return int'(t);
    endfunction

    function automatic sym_t mk(input int run, input int v, input bit dc, input bit eob, input bit last);
        sym_t s;
        int   sz;
        int   a;
        int   amp;
        sz = 0;
        a  = (v < 0) ? -v : v;
        while ((1 << sz) <= a) sz++;
        amp    = (v >= 0) ? v : v + (1 << sz) - 1;
        s.run  = 4'(run);
        s.size = 4'(sz);
        s.amp  = 12'(amp);
        s.dc   = dc;
        s.eob  = eob;
        s.last = last;
        return s;
    endfunction

    // Reference: walk the anti-diagonals for zigzag order, then plain JPEG run-length coding.
    task automatic build_expect();
        int order [64];
        int idx;
        int run;
        int v;
        int d;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    order[idx] = r * 8 + (s - r); idx++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    order[idx] = r * 8 + (s - r); idx++;
                end
            end
        end
        v = conv(coefs[0]);
`ifdef ZIGZAG_RLE_DC_DIFF_EN
        d = v - pred;
        pred = v;
`else
        d = v;
`endif
        expq.push_back(mk(0, d, 1'b1, 1'b0, 1'b0));
        run = 0;
        for (int k = 1; k < 64; k++) begin
            v = conv(coefs[order[k]]);
            if (v == 0) begin
                run++;
            end else begin
                while (run > 15) begin
                    expq.push_back(mk(15, 0, 1'b0, 1'b0, 1'b0));
                    run -= 16;
                end
                expq.push_back(mk(run, v, 1'b0, 1'b0, k == 63));
                run = 0;
            end
        end
        if (conv(coefs[order[63]]) == 0) expq.push_back(mk(0, 0, 1'b0, 1'b1, 1'b1));
    endtask

    always @(negedge clk) begin
        sym_t a;
        sym_t e;
        if (!reset && sym_valid && sym_ready) begin
            a = {sym_run, sym_size, sym_amp, sym_dc, sym_eob, sym_last};
            if (expq.size() == 0) begin
                chk("sym_unexpected", int'(a), -1);
            end else begin
                e = expq.pop_front();
                chk("sym", int'(a), int'(e));
            end
        end
    end

    task automatic clear_coefs();
        for (int i = 0; i < 64; i++) coefs[i] = 0;
    endtask

    // Returns in cycle 1 (one #1 after the handshake edge).
    task automatic send_block();
        int n;
        n = 0;
        while (!blk_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("blk_ready_wait", int'(blk_ready), 1);
        build_expect();
        for (int i = 0; i < 64; i++) blk_coef[i*COEF_W +: COEF_W] = coefs[i];
        blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        blk_coef  = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string nm, input int exp_cyc, input int cur);
        int n;
        n = cur;
        while (!blk_ready && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk(nm, n, exp_cyc);
        chk({nm, "_drained"}, expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_sym", int'({sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_eob, sym_last}), 0);
        chk("rst_ready", int'({blk_ready, busy}), 2);
        reset = 1'b0;
        step(1);

        // Rounding of 16.5, all-zero AC
        clear_coefs();
        coefs[0] = 32'h0000_1080;
        send_block();
        chk("t1_dc", int'({sym_valid, sym_dc, sym_run, sym_size, sym_amp}), (3 << 20) | (5 << 12) | 17);
        step(63);
        chk("t1_eob", int'({sym_valid, sym_eob, sym_last, blk_ready}), 4'b1110);
        wait_done("t1_done", 65, 64);

        // Negative amplitude
        clear_coefs();
        coefs[1] = 32'hFFFF_FD00;
        coefs[8] = 32'h0000_0500;
        send_block();
        chk("t2_dc", int'({sym_size, sym_amp}), 0);
        step(1);
        chk("t2_neg", int'({sym_run, sym_size, sym_amp}), (2 << 12) | 0);
        step(1);
        chk("t2_pos", int'({sym_run, sym_size, sym_amp}), (3 << 12) | 5);
        wait_done("t2_done", 65, 3);

        // Two ZRLs before index 40
        clear_coefs();
        coefs[29] = 256;
        send_block();
        step(42);
        chk("t3_sym", int'({sym_valid, sym_run, sym_size, sym_amp}), (1 << 20) | (7 << 16) | (1 << 12) | 1);
        wait_done("t3_done", 67, 43);

        // Trailing coefficient, no EOB
        clear_coefs();
        coefs[63] = 512;
        send_block();
        step(66);
        chk("t4_last", int'({sym_run, sym_size, sym_amp, sym_last}), (14 << 17) | (2 << 13) | (2 << 1) | 1);
        step(1);
        chk("t4_idle", int'({sym_valid, blk_ready}), 1);
        wait_done("t4_done", 68, 68);

        // Same block under 10 cycles of backpressure on the DC symbol
        sym_ready = 1'b0;
        send_block();
        for (int n = 1; n <= 10; n++) begin
            chk("t5_hold", int'({sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_eob, sym_last}), (1 << 23) | 4);
            if (n < 10) step(1);
        end
        step(1);
        sym_ready = 1'b1;
        wait_done("t5_done", 78, 11);

        // Saturation, DC on second block, mid-block reset
        clear_coefs();
        coefs[0] = 32'h000B_B800;
        send_block();
        chk("t6_sat", int'({sym_run, sym_size, sym_amp}), (11 << 12) | 2047);
        wait_done("t6a_done", 65, 1);
        coefs[0] = 0;
        send_block();
`ifdef ZIGZAG_RLE_DC_DIFF_EN
        chk("t6_diff", int'({sym_dc, sym_size, sym_amp}), (1 << 16) | (11 << 12));
`else
        chk("t6_abs", int'({sym_dc, sym_size, sym_amp}), (1 << 16));
`endif
        step(4);
        chk("t6_busy", int'(busy), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_rst", int'({sym_valid, blk_ready, busy}), 3'b010);
        expq.delete();
        pred = 0;

        // Predictor cleared by reset
        coefs[0] = 1280;
        send_block();
        chk("t7_dc", int'({sym_run, sym_size, sym_amp}), (3 << 12) | 5);
        wait_done("t7_done", 65, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
